posit8_mul_core: RTL and testbench

Sequential multiplier stage directly downstream of the 8-bit posit (es=1) field decoder. Accepts the decoded fields of two operands over a valid/ready handshake: sign, regime k, exponent bit, 4-bit fraction, zero flag and NaR flag. Multiplies the significands with an iterative shift-add datapath and adds the scales. Emits an unrounded product as sign, scale, 8-bit fraction, sticky and special flags, for the downstream posit encoder/rounder.

---
 rtl/posit8_mul_core.sv | 162 ++++++++++++++++
 tb/tb_posit8_mul_core.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/posit8_mul_core.sv
// Posit8 (es=1) multiply stage: sequential shift-add significand multiply plus
// scale addition, producing an unrounded normalized product for the encoder.
module posit8_mul_core (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       a_sign,
   input  logic       b_sign,
   input  logic [3:0] a_regi,
   input  logic [3:0] b_regi,
   input  logic       a_expo,
   input  logic       b_expo,
   input  logic [3:0] a_frac,
   input  logic [3:0] b_frac,
   input  logic       a_zero,
   input  logic       b_zero,
   input  logic       a_nar,
   input  logic       b_nar,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       out_sign,
   output logic [6:0] out_scale,
   output logic [7:0] out_frac,
   output logic       out_sticky,
   output logic       out_zero,
   output logic       out_nar
);

   typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

   state_t             state_q, state_d;
   logic               sign_q, sign_d;
   logic signed [6:0]  scale_q, scale_d;
   logic               zero_q, zero_d;
   logic               nar_q, nar_d;
   logic [4:0]         mcand_q, mcand_d;
   logic [4:0]         mplier_q, mplier_d;
   logic [9:0]         acc_q, acc_d;
   logic [2:0]         cnt_q, cnt_d;

   logic               osign_q, osign_d;
   logic signed [6:0]  oscale_q, oscale_d;
   logic [7:0]         ofrac_q, ofrac_d;
   logic               osticky_q, osticky_d;
   logic               ozero_q, ozero_d;
   logic               onar_q, onar_d;

   // Scale of one operand is 2*k + e; {k, e} is exactly that value in 5 bits.
   function automatic logic signed [6:0] op_scale(input logic [3:0] regi, input logic expo);
      return {{2{regi[3]}}, regi, expo};
   endfunction

   // Drop the leading 1 of the 10-bit product; returns {frac, sticky}.
   function automatic logic [8:0] norm_frac(input logic [9:0] prod);
      if (prod[9]) return {prod[8:1], prod[0]};
      else         return {prod[7:0], 1'b0};
   endfunction

   assign in_ready   = (state_q == IDLE);
   assign out_valid  = (state_q == DONE);
   assign out_sign   = osign_q;
   assign out_scale  = oscale_q;
   assign out_frac   = ofrac_q;
   assign out_sticky = osticky_q;
   assign out_zero   = ozero_q;
   assign out_nar    = onar_q;

   always_comb begin
      state_d   = state_q;
      sign_d    = sign_q;
      scale_d   = scale_q;
      zero_d    = zero_q;
      nar_d     = nar_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      osign_d   = osign_q;
      oscale_d  = oscale_q;
      ofrac_d   = ofrac_q;
      osticky_d = osticky_q;
      ozero_d   = ozero_q;
      onar_d    = onar_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               sign_d   = a_sign ^ b_sign;
               scale_d  = op_scale(a_regi, a_expo) + op_scale(b_regi, b_expo);
               nar_d    = a_nar | b_nar;
               zero_d   = (a_zero | b_zero) & ~(a_nar | b_nar);
               mcand_d  = {1'b1, a_frac};
               mplier_d = {1'b1, b_frac};
               acc_d    = '0;
               cnt_d    = '0;
               state_d  = (a_nar | b_nar | a_zero | b_zero) ? NORM : MUL;
            end
         end
         MUL: begin
            if (mplier_q[cnt_q])
               acc_d = acc_q + ({5'b0, mcand_q} << cnt_q);
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd4)
               state_d = NORM;
         end
         NORM: begin
            // Specials carry only their flag; every numeric field is forced to 0.
            if (nar_q | zero_q) begin
               osign_d   = 1'b0;
               oscale_d  = '0;
               ofrac_d   = '0;
               osticky_d = 1'b0;
            end else begin
               osign_d                = sign_q;
               oscale_d               = acc_q[9] ? scale_q + 7'sd1 : scale_q;
               {ofrac_d, osticky_d}   = norm_frac(acc_q);
            end
            ozero_d = zero_q;
            onar_d  = nar_q;
            state_d = DONE;
         end
         DONE: begin
            if (out_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         osign_q   <= 1'b0;
         oscale_q  <= '0;
         ofrac_q   <= '0;
         osticky_q <= 1'b0;
         ozero_q   <= 1'b0;
         onar_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         osign_q   <= osign_d;
         oscale_q  <= oscale_d;
         ofrac_q   <= ofrac_d;
         osticky_q <= osticky_d;
         ozero_q   <= ozero_d;
         onar_q    <= onar_d;
      end
   end

   // Working datapath registers need no reset: IDLE reloads them on every accept.
   always_ff @(posedge clk) begin
      sign_q   <= sign_d;
      scale_q  <= scale_d;
      zero_q   <= zero_d;
      nar_q    <= nar_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
   end

endmodule

// File: tb/tb_posit8_mul_core.sv
// Directed/scoreboard bench for posit8_mul_core: expected products are queued
// when operands are driven and compared when the result appears.
module tb_posit8_mul_core;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid, in_ready;
   logic       a_sign, b_sign;
   logic [3:0] a_regi, b_regi;
   logic       a_expo, b_expo;
   logic [3:0] a_frac, b_frac;
   logic       a_zero, b_zero, a_nar, b_nar;
   logic       out_valid, out_ready;
   logic       out_sign;
   logic [6:0] out_scale;
   logic [7:0] out_frac;
   logic       out_sticky, out_zero, out_nar;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic       sign;
      logic [3:0] regi;
      logic       expo;
      logic [3:0] frac;
      logic       zero;
      logic       nar;
   } opnd_t;

   typedef struct packed {
      logic       sign;
      logic [6:0] scale;
      logic [7:0] frac;
      logic       sticky;
      logic       zero;
      logic       nar;
      int         lat;
   } exp_t;

   exp_t sb[$];

   posit8_mul_core dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a_sign(a_sign), .b_sign(b_sign), .a_regi(a_regi), .b_regi(b_regi),
      .a_expo(a_expo), .b_expo(b_expo), .a_frac(a_frac), .b_frac(b_frac),
      .a_zero(a_zero), .b_zero(b_zero), .a_nar(a_nar), .b_nar(b_nar),
      .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign),
      .out_scale(out_scale), .out_frac(out_frac), .out_sticky(out_sticky),
      .out_zero(out_zero), .out_nar(out_nar)
   );

   always #5 clk = ~clk;

   function automatic opnd_t mk(input logic s, input logic [3:0] k, input logic e,
                                input logic [3:0] f, input logic z, input logic n);
      opnd_t o;
      o.sign = s; o.regi = k; o.expo = e; o.frac = f; o.zero = z; o.nar = n;
      return o;
   endfunction

   function automatic exp_t mkexp(input logic s, input logic [6:0] sc, input logic [7:0] f,
                                  input logic st, input logic z, input logic n, input int lat);
      exp_t e;
      e.sign = s; e.scale = sc; e.frac = f; e.sticky = st; e.zero = z; e.nar = n; e.lat = lat;
      return e;
   endfunction

   // Arithmetic reference for normal operands, computed on integer values.
   function automatic exp_t model(input opnd_t a, input opnd_t b);
      int p, sc;
      exp_t e;
      p  = (16 + int'(a.frac)) * (16 + int'(b.frac));
      sc = 2 * int'($signed(a.regi)) + int'(a.expo) + 2 * int'($signed(b.regi)) + int'(b.expo);
      e  = mkexp(a.sign ^ b.sign, 7'd0, 8'd0, 1'b0, 1'b0, 1'b0, 6);
      if (p >= 512) begin
         sc = sc + 1;
         e.frac   = 8'((p >> 1) & 255);
         e.sticky = p[0];
      end else begin
         e.frac   = 8'(p & 255);
      end
      e.scale = 7'(sc);
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic drive(input opnd_t a, input opnd_t b, input logic v);
      a_sign = a.sign; a_regi = a.regi; a_expo = a.expo; a_frac = a.frac;
      a_zero = a.zero; a_nar = a.nar;
      b_sign = b.sign; b_regi = b.regi; b_expo = b.expo; b_frac = b.frac;
      b_zero = b.zero; b_nar = b.nar;
      in_valid = v;
   endtask

   task automatic cmp_fields(input string tag, input exp_t e);
      chk({tag, ".sign"},   32'(out_sign),   32'(e.sign));
      chk({tag, ".scale"},  32'(out_scale),  32'(e.scale));
      chk({tag, ".frac"},   32'(out_frac),   32'(e.frac));
      chk({tag, ".sticky"}, 32'(out_sticky), 32'(e.sticky));
      chk({tag, ".zero"},   32'(out_zero),   32'(e.zero));
      chk({tag, ".nar"},    32'(out_nar),    32'(e.nar));
   endtask

   // Accept one operand pair, wait for the result, compare against the queue head.
   task automatic do_op(input string tag, input opnd_t a, input opnd_t b, input exp_t e,
                        output exp_t got);
      int n;
      @(negedge clk);
      chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
      drive(a, b, 1'b1);
      sb.push_back(e);
      @(posedge clk);
      #1 in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clk);
         #1 n++;
      end
      got = sb.pop_front();
      chk({tag, ".latency"}, 32'(n), 32'(got.lat));
      cmp_fields(tag, got);
      if (out_ready) begin
         @(posedge clk);
         #1;
         chk({tag, ".vld_drop"}, 32'(out_valid), 32'd0);
         chk({tag, ".ready_back"}, 32'(in_ready), 32'd1);
      end
   endtask

   initial begin
      exp_t  e, got;
      opnd_t a, b, one, big;
      bit    seen;

      rst = 1'b1;
      out_ready = 1'b1;
      drive(mk(0, 0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0, 0), 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst.in_ready", 32'(in_ready), 32'd1);
      chk("rst.out_valid", 32'(out_valid), 32'd0);
      cmp_fields("rst", mkexp(0, 7'd0, 8'd0, 0, 0, 0, 0));
      rst = 1'b0;

      one = mk(0, 4'd0, 0, 4'b0000, 0, 0);
      do_op("one_x_one", one, one, mkexp(0, 7'd0, 8'h00, 0, 0, 0, 6), got);

      do_op("p15_x_m15", mk(0, 4'd0, 0, 4'b1000, 0, 0), mk(1, 4'd0, 0, 4'b1000, 0, 0),
            mkexp(1, 7'd1, 8'h20, 0, 0, 0, 6), got);

      big = mk(0, 4'd6, 1, 4'b1111, 0, 0);
      do_op("maxpos", big, big, mkexp(0, 7'd27, 8'hE0, 1, 0, 0, 6), got);

      a = mk(0, 4'b1001, 0, 4'b0000, 0, 0);
      do_op("minpos", a, a, mkexp(0, 7'b1100100, 8'h00, 0, 0, 0, 6), got);

      do_op("zero_x_nar", mk(0, 0, 0, 0, 1, 0), mk(0, 0, 0, 0, 0, 1),
            mkexp(0, 7'd0, 8'h00, 0, 0, 1, 1), got);

      do_op("zero_x_norm", mk(1, 4'd3, 1, 4'b0110, 1, 0), mk(0, 4'd2, 1, 4'b1011, 0, 0),
            mkexp(0, 7'd0, 8'h00, 0, 1, 0, 1), got);

      for (int i = 0; i < 6; i++) begin
         a = mk(1'($urandom_range(0, 1)), 4'($urandom_range(0, 13) - 7), 1'($urandom_range(0, 1)),
                4'($urandom_range(0, 15)), 0, 0);
         b = mk(1'($urandom_range(0, 1)), 4'($urandom_range(0, 13) - 7), 1'($urandom_range(0, 1)),
                4'($urandom_range(0, 15)), 0, 0);
         do_op($sformatf("rand%0d", i), a, b, model(a, b), got);
      end

      // Backpressure: result must hold and new operands must be refused.
      out_ready = 1'b0;
      do_op("bp", mk(0, 0, 0, 4'b1000, 0, 0), one, mkexp(0, 7'd0, 8'h80, 0, 0, 0, 6), got);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         drive(big, big, 1'b1);
         @(posedge clk);
         #1;
         chk("bp.hold_valid", 32'(out_valid), 32'd1);
         chk("bp.in_ready", 32'(in_ready), 32'd0);
         cmp_fields("bp.hold", got);
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp.release_valid", 32'(out_valid), 32'd0);
      chk("bp.release_ready", 32'(in_ready), 32'd1);
      seen = 1'b0;
      repeat (10) begin
         @(posedge clk);
         #1 if (out_valid) seen = 1'b1;
      end
      chk("bp.no_stray", 32'(seen), 32'd0);
      chk("sb.empty", 32'(sb.size()), 32'd0);

      // Reset at T+3 of an in-flight multiply discards it.
      @(negedge clk);
      drive(big, one, 1'b1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("midrst.in_ready", 32'(in_ready), 32'd1);
      chk("midrst.out_valid", 32'(out_valid), 32'd0);
      seen = 1'b0;
      repeat (10) begin
         @(posedge clk);
         #1 if (out_valid) seen = 1'b1;
      end
      chk("midrst.never_valid", 32'(seen), 32'd0);

      do_op("after_rst", one, one, mkexp(0, 7'd0, 8'h00, 0, 0, 0, 6), got);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
